ks_note_sequencer: RTL and testbench

Step sequencer that plays the Karplus-Strong string autonomously. It holds a small table of notes, each a period and a duration in sample ticks, and steps through the table. For each note it presents the period to `ks_string`, asserts `pluck` for a fixed number of sample ticks, then waits out the duration. It sits between the SPI register map, which supplies table writes and start/stop/loop controls, and the `ks_string` inputs `period_i` and `pluck_i`.

---
 rtl/ks_seq_pkg.sv | 24 ++
 rtl/ks_seq_step_mem.sv | 43 ++++
 rtl/ks_note_sequencer.sv | 171 +++++++++++++++++
 tb/tb_ks_note_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_seq_pkg.sv
// Shared types and defaults for the Karplus-Strong note sequencer.
package ks_seq_pkg;

    // Sequencer control states; ADVANCE is a transition, not a state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_e;

    // Sample ticks the pluck request stays high at the start of a note.
    localparam int DEFAULT_PLUCK_TICKS = 2;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DUR_WIDTH  = 8;

    // One table entry at the default widths: duration in the upper field,
    // period in the lower field. Instances with other widths keep this layout.
    typedef struct packed {
        logic [DEFAULT_DUR_WIDTH-1:0]  dur;
        logic [DEFAULT_DATA_WIDTH-1:0] period;
    } step_t;

endpackage

// File: rtl/ks_seq_step_mem.sv
// Step table: NUM_STEPS entries, synchronous write, asynchronous read,
// synchronous clear on reset.
module ks_seq_step_mem
    import ks_seq_pkg::*;
#(
    parameter int  NUM_STEPS = 8,
    parameter type entry_t   = step_t
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we_i,
    input  logic [$clog2(NUM_STEPS)-1:0] waddr_i,
    input  entry_t                       wdata_i,
    input  logic [$clog2(NUM_STEPS)-1:0] raddr_i,
    output entry_t                       rdata_o
);

    entry_t mem_q [NUM_STEPS];
    entry_t mem_d [NUM_STEPS];

    // Next table contents: keep everything, overwrite the addressed entry.
    always_comb begin
        // NOTE: assign a default before any conditional update so every path drives the signal; otherwise a latch is inferred.
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Table storage, cleared to all-zero entries on reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values; blocking here would create order-dependent races.
        if (!rst_n) begin
            // NOTE: this table is deliberately reset (a zero entry is a defined rest); large RAM-style memories normally are not, so they can map to RAM macros.
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ks_note_sequencer.sv
// Step sequencer driving ks_string: walks the note table, presents each
// period, pulses pluck for PLUCK_TICKS sample ticks and waits out the duration.
module ks_note_sequencer
    import ks_seq_pkg::*;
#(
    parameter int NUM_STEPS   = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int DUR_WIDTH   = 8,
    parameter int PLUCK_TICKS = DEFAULT_PLUCK_TICKS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_tick_i,
    input  logic                         cfg_we_i,
    input  logic [$clog2(NUM_STEPS)-1:0] cfg_addr_i,
    input  logic [DATA_WIDTH-1:0]        cfg_period_i,
    input  logic [DUR_WIDTH-1:0]         cfg_dur_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    input  logic                         loop_en_i,
    input  logic [$clog2(NUM_STEPS):0]   length_i,
    output logic [DATA_WIDTH-1:0]        period_o,
    output logic                         pluck_o,
    output logic [$clog2(NUM_STEPS)-1:0] step_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int AW = $clog2(NUM_STEPS);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [DUR_WIDTH-1:0]  dur;
        logic [DATA_WIDTH-1:0] period;
    } entry_t;

    entry_t wr_entry;
    entry_t rd_entry;

    state_e                state_q,  state_d;
    logic [AW-1:0]         step_q,   step_d;
    logic [LW-1:0]         len_q,    len_d;
    logic [DUR_WIDTH-1:0]  cnt_q,    cnt_d;
    logic [DUR_WIDTH-1:0]  dur_q,    dur_d;
    logic [DATA_WIDTH-1:0] period_q, period_d;
    logic                  pluck_q,  pluck_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic                  advance;

    assign wr_entry = '{dur: cfg_dur_i, period: cfg_period_i};

    ks_seq_step_mem #(
        .NUM_STEPS (NUM_STEPS),
        .entry_t   (entry_t)
    ) u_step_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (cfg_we_i),
        .waddr_i (cfg_addr_i),
        .wdata_i (wr_entry),
        .raddr_i (step_q),
        .rdata_o (rd_entry)
    );

    // Next-state and next-output logic for the IDLE/LOAD/PLAY sequencer.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        dur_d    = dur_q;
        period_d = period_q;
        done_d   = 1'b0;
        advance  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && (length_i != '0)) begin
                    state_d = ST_LOAD;
                    step_d  = '0;
                    len_d   = (length_i > LW'(NUM_STEPS)) ? LW'(NUM_STEPS) : length_i;
                end
            end
            ST_LOAD: begin
                // The period is latched here, so later table writes to this
                // step only take effect at its next LOAD.
                period_d = rd_entry.period;
                dur_d    = rd_entry.dur;
                cnt_d    = '0;
                if (rd_entry.dur == '0) begin
                    advance = 1'b1;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (sample_tick_i) begin
                    if (cnt_q + DUR_WIDTH'(1) == dur_q) begin
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + DUR_WIDTH'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if ((LW'(step_q) + LW'(1)) < len_q) begin
                step_d  = step_q + AW'(1);
                state_d = ST_LOAD;
            end else if (loop_en_i) begin
                step_d  = '0;
                state_d = ST_LOAD;
            end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end

        // Abort overrides everything: back to IDLE with the visible
        // period/step frozen and no completion pulse.
        if (stop_i) begin
            state_d  = ST_IDLE;
            step_d   = step_q;
            len_d    = len_q;
            cnt_d    = cnt_q;
            dur_d    = dur_q;
            period_d = period_q;
            done_d   = 1'b0;
        end

        // Pluck is high for the first PLUCK_TICKS ticks of PLAY; a short
        // note leaves PLAY earlier, which truncates it naturally.
        pluck_d = (state_d == ST_PLAY) && (32'(cnt_d) < 32'(PLUCK_TICKS));
        busy_d  = (state_d != ST_IDLE);
    end

    // Sequencer registers, all outputs included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            dur_q    <= '0;
            period_q <= '0;
            pluck_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            dur_q    <= dur_d;
            period_q <= period_d;
            pluck_q  <= pluck_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign period_o = period_q;
    assign pluck_o  = pluck_q;
    assign step_o   = step_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Self-checking bench for ks_note_sequencer: directed scenarios plus random
// tables, compared against a note-level model of what should be played.
module tb_ks_note_sequencer;

    localparam int NS = 8;
    localparam int PT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_tick_i = 1'b0;
    logic       cfg_we_i = 1'b0;
    logic [2:0] cfg_addr_i = '0;
    logic [7:0] cfg_period_i = '0;
    logic [7:0] cfg_dur_i = '0;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic       loop_en_i = 1'b0;
    logic [3:0] length_i = '0;
    logic [7:0] period_o;
    logic       pluck_o;
    logic [2:0] step_o;
    logic       busy_o;
    logic       done_o;

    ks_note_sequencer #(
        .NUM_STEPS   (NS),
        .DATA_WIDTH  (8),
        .DUR_WIDTH   (8),
        .PLUCK_TICKS (PT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_tick_i (sample_tick_i),
        .cfg_we_i      (cfg_we_i),
        .cfg_addr_i    (cfg_addr_i),
        .cfg_period_i  (cfg_period_i),
        .cfg_dur_i     (cfg_dur_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .loop_en_i     (loop_en_i),
        .length_i      (length_i),
        .period_o      (period_o),
        .pluck_o       (pluck_o),
        .step_o        (step_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    // Sample tick: one clk wide, every 16 clk.
    int tick_phase = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick_phase    = (tick_phase + 1) % 16;
            sample_tick_i = (tick_phase == 0);
        end
    end

    // Observed notes: each pluck pulse with its step, period and length in ticks.
    typedef struct {
        int step;
        int period;
        int len;
    } note_t;

    note_t obs_q[$];
    note_t cur;
    logic  pluck_prev  = 1'b0;
    int    busy_ticks  = 0;
    int    done_pulses = 0;
    int    pluck_rises = 0;

    always @(negedge clk) begin
        if (pluck_o && !pluck_prev) begin
            cur.step   = int'(step_o);
            cur.period = int'(period_o);
            cur.len    = 0;
            pluck_rises++;
        end
        if (pluck_o && sample_tick_i) cur.len++;
        if (!pluck_o && pluck_prev) obs_q.push_back(cur);
        if (busy_o && sample_tick_i) busy_ticks++;
        if (done_o) done_pulses++;
        pluck_prev = pluck_o;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bench copy of the table contents.
    int tp[NS];
    int td[NS];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input int a, input int p, input int d);
        cfg_we_i     = 1'b1;
        cfg_addr_i   = 3'(a);
        cfg_period_i = 8'(p);
        cfg_dur_i    = 8'(d);
        step();
        cfg_we_i = 1'b0;
        tp[a] = p;
        td[a] = d;
    endtask

    // Wait until a tick has just been consumed so LOAD cycles never meet a tick.
    task automatic align();
        do step(); while (tick_phase != 1);
    endtask

    task automatic pulse_start(input int len);
        length_i = 4'(len);
        start_i  = 1'b1;
        step();
        start_i  = 1'b0;
    endtask

    task automatic wait_rises(input int target, input string tag);
        int cyc = 0;
        while (pluck_rises < target && cyc < 3000) begin
            step();
            cyc++;
        end
        check(tag, 32'(pluck_rises >= target), 1);
    endtask

    // Play a non-looping sequence and compare against the note-level model.
    task automatic run_expect(input int length, input string name);
        note_t exp_q[$];
        note_t e;
        int L, tot, n0, bt0, dp0, cyc, n_obs, n_cmp;
        L   = (length > NS) ? NS : length;
        tot = 0;
        for (int i = 0; i < L; i++) begin
            if (td[i] > 0) begin
                e.step   = i;
                e.period = tp[i];
                e.len    = (td[i] < PT) ? td[i] : PT;
                exp_q.push_back(e);
            end
            tot += td[i];
        end
        loop_en_i = 1'b0;
        align();
        n0  = obs_q.size();
        bt0 = busy_ticks;
        dp0 = done_pulses;
        pulse_start(length);
        check({name, ".busy_after_start"}, 32'(busy_o), 1);
        cyc = 0;
        while (busy_o && cyc < 4000) begin
            step();
            cyc++;
        end
        check({name, ".finished"}, 32'(cyc < 4000), 1);
        step();
        step();
        n_obs = obs_q.size() - n0;
        check({name, ".n_notes"}, n_obs, exp_q.size());
        n_cmp = (n_obs < exp_q.size()) ? n_obs : exp_q.size();
        for (int k = 0; k < n_cmp; k++) begin
            check($sformatf("%s.note%0d.step", name, k),   obs_q[n0+k].step,   exp_q[k].step);
            check($sformatf("%s.note%0d.period", name, k), obs_q[n0+k].period, exp_q[k].period);
            check($sformatf("%s.note%0d.pluck", name, k),  obs_q[n0+k].len,    exp_q[k].len);
        end
        check({name, ".ticks"}, busy_ticks - bt0, tot);
        check({name, ".done"}, done_pulses - dp0, 1);
        check({name, ".step_end"}, 32'(step_o), L - 1);
        check({name, ".period_end"}, 32'(period_o), tp[L-1]);
        check({name, ".busy_end"}, 32'(busy_o), 0);
    endtask

    initial begin
        int n0, dp0;

        // Reset state.
        for (int i = 0; i < NS; i++) begin
            tp[i] = 0;
            td[i] = 0;
        end
        step();
        step();
        check("rst.period", 32'(period_o), 0);
        check("rst.pluck",  32'(pluck_o), 0);
        check("rst.step",   32'(step_o), 0);
        check("rst.busy",   32'(busy_o), 0);
        check("rst.done",   32'(done_o), 0);
        rst_n = 1'b1;
        step();

        // Three-step run.
        cfg_write(0, 8'h20, 4);
        cfg_write(1, 8'h40, 3);
        cfg_write(2, 8'h60, 5);
        run_expect(3, "three");

        // Rest followed by a truncated pluck.
        cfg_write(0, 8'h31, 0);
        cfg_write(1, 8'h32, 1);
        run_expect(2, "rest");

        // Loop, then stop during the second pass.
        cfg_write(0, 8'h11, 3);
        cfg_write(1, 8'h22, 3);
        align();
        n0  = obs_q.size();
        dp0 = done_pulses;
        loop_en_i = 1'b1;
        pulse_start(2);
        wait_rises(pluck_rises + 4, "loop.rises");
        check("loop.note0.step", obs_q[n0].step,   0);
        check("loop.note1.step", obs_q[n0+1].step, 1);
        check("loop.wrap.step",  obs_q[n0+2].step, 0);
        check("loop.pass2.step", 32'(step_o), 1);
        repeat (5) step();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        check("stop.busy",   32'(busy_o), 0);
        check("stop.pluck",  32'(pluck_o), 0);
        check("stop.period", 32'(period_o), 8'h22);
        check("stop.step",   32'(step_o), 1);
        repeat (3) step();
        check("stop.no_done", done_pulses - dp0, 0);
        loop_en_i = 1'b0;

        // Zero length is ignored; oversize length is clamped.
        pulse_start(0);
        step();
        check("len0.busy", 32'(busy_o), 0);
        for (int i = 0; i < NS; i++) cfg_write(i, $urandom_range(1, 255), $urandom_range(1, 3));
        run_expect(12, "clamp");

        // start and stop together in IDLE.
        length_i = 4'd3;
        start_i  = 1'b1;
        stop_i   = 1'b1;
        step();
        start_i  = 1'b0;
        stop_i   = 1'b0;
        check("startstop.busy0", 32'(busy_o), 0);
        step();
        check("startstop.busy1", 32'(busy_o), 0);

        // Rewriting the playing step only shows up at its next LOAD.
        cfg_write(0, 8'h30, 3);
        align();
        loop_en_i = 1'b1;
        pulse_start(1);
        wait_rises(pluck_rises + 1, "rewrite.rise1");
        repeat (3) step();
        check("rewrite.before", 32'(period_o), 8'h30);
        cfg_write(0, 8'h55, 3);
        step();
        check("rewrite.hold", 32'(period_o), 8'h30);
        wait_rises(pluck_rises + 1, "rewrite.rise2");
        check("rewrite.after", 32'(period_o), 8'h55);

        // Reset mid-PLAY clears outputs and the table.
        repeat (3) step();
        check("midrst.pluck_pre", 32'(pluck_o), 1);
        rst_n = 1'b0;
        step();
        check("midrst.period", 32'(period_o), 0);
        check("midrst.pluck",  32'(pluck_o), 0);
        check("midrst.step",   32'(step_o), 0);
        check("midrst.busy",   32'(busy_o), 0);
        check("midrst.done",   32'(done_o), 0);
        rst_n     = 1'b1;
        loop_en_i = 1'b0;
        for (int i = 0; i < NS; i++) begin
            tp[i] = 0;
            td[i] = 0;
        end
        step();
        run_expect(1, "post_rst");

        // Random tables and lengths.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NS; i++) cfg_write(i, $urandom_range(0, 255), $urandom_range(0, 5));
            run_expect($urandom_range(1, 12), $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
